// File: rtl/vram_pkg.sv
// Shared constants and types for the sprite tile VRAM and its line-fetch clients.
package vram_pkg;

   localparam int VRAM_SPRITES = 64;
   localparam int SPRITE_ROWS  = 32;
   localparam int LINE_PIX     = 32;
   localparam int PIX_W        = 8;
   localparam int LINE_ADDR_W  = 12;

   typedef logic [LINE_PIX*PIX_W-1:0] sprite_line_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      STREAM = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/vram_tile_line_fetcher.sv
// Fetches one 256-bit sprite line from the tile RAM and streams it to the renderer
// one pixel per handshake, optionally mirrored, with back-to-back request chaining.
module vram_tile_line_fetcher
   import vram_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int PIX_W        = 8,
   parameter int LINE_PIX     = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [5:0]                req_sprite,
   input  logic [4:0]                req_row,
   input  logic                      req_flip_x,
   output logic [LINE_ADDR_W-1:0]    mem_read_addr,
   input  logic [LINE_PIX*PIX_W-1:0] mem_read_data,
   output logic                      pix_valid,
   input  logic                      pix_ready,
   output logic [PIX_W-1:0]          pix_data,
   output logic                      pix_last,
   output logic                      busy
);

   localparam int LINE_W = LINE_PIX * PIX_W;
   localparam int CNT_W  = $clog2(LINE_PIX);
   localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;

   fetch_state_t      state;
   logic [CNT_W-1:0]  pix_cnt;
   logic [LAT_W-1:0]  lat_cnt;
   logic              flip;
   logic [LINE_W-1:0] line;

   logic pix_fire;
   logic at_last;
   logic accept;

   assign pix_valid = (state == STREAM);
   assign busy      = (state != IDLE);
   assign pix_fire  = pix_valid && pix_ready;
   assign at_last   = (pix_cnt == CNT_W'(LINE_PIX - 1));
   assign pix_last  = pix_valid && at_last;

   // NOTE: req_ready is gated by reset_n directly so a request held during reset is never
   // seen as accepted, even though the state register already reads IDLE.
   assign req_ready = reset_n && ((state == IDLE) || (pix_fire && at_last));
   assign accept    = req_valid && req_ready;

   // The head pixel always sits at one end of the line register; mirroring picks the end.
   assign pix_data  = flip ? line[LINE_W-1 -: PIX_W] : line[PIX_W-1:0];

   // NOTE: the line register is a plain datapath register, but it is cleared on reset
   // as well so pix_data reads zero until the first line is captured.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         mem_read_addr <= '0;
         flip          <= 1'b0;
         lat_cnt       <= '0;
         pix_cnt       <= '0;
         line          <= '0;
      end else begin
         if (accept) begin
            mem_read_addr <= LINE_ADDR_W'({req_sprite, req_row});
            flip          <= req_flip_x;
            lat_cnt       <= LAT_W'(READ_LATENCY);
         end

         case (state)
            IDLE: begin
               if (accept) state <= WAIT;
            end

            WAIT: begin
               if (lat_cnt == '0) begin
                  line    <= mem_read_data;
                  pix_cnt <= '0;
                  state   <= STREAM;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end

            STREAM: begin
               if (pix_fire) begin
                  pix_cnt <= pix_cnt + 1'b1;
                  line    <= flip ? (line << PIX_W) : (line >> PIX_W);
                  if (at_last) state <= accept ? WAIT : IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_tile_line_fetcher.sv
// Directed bench for the tile line fetcher with a behavioural tile RAM read port
// (word address a holds a[15:0]) and a pixel scoreboard.
module tb_vram_tile_line_fetcher;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [5:0]   req_sprite = '0;
   logic [4:0]   req_row = '0;
   logic         req_flip_x = 1'b0;
   logic [11:0]  mem_read_addr;
   logic [255:0] mem_read_data = '0;
   logic         pix_valid;
   logic         pix_ready = 1'b0;
   logic [7:0]   pix_data;
   logic         pix_last;
   logic         busy;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } pix_t;

   pix_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   hs_count = 0;

   vram_tile_line_fetcher #(.READ_LATENCY(1), .PIX_W(8), .LINE_PIX(32)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_sprite    (req_sprite),
      .req_row       (req_row),
      .req_flip_x    (req_flip_x),
      .mem_read_addr (mem_read_addr),
      .mem_read_data (mem_read_data),
      .pix_valid     (pix_valid),
      .pix_ready     (pix_ready),
      .pix_data      (pix_data),
      .pix_last      (pix_last),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] line_of(input logic [11:0] a);
      logic [255:0] l;
      for (int k = 0; k < 16; k++) l[16*k +: 16] = {a, 4'(k)};
      return l;
   endfunction

   // Tile RAM read port with one clock of latency.
   always @(posedge clk) mem_read_data <= line_of(mem_read_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_line(input logic [11:0] a, input logic f);
      logic [255:0] l;
      pix_t         e;
      int           n;
      l = line_of(a);
      for (int i = 0; i < 32; i++) begin
         n      = f ? 31 - i : i;
         e.data = l[8*n +: 8];
         e.last = (i == 31);
         exp_q.push_back(e);
      end
   endtask

   // Pixel monitor: stall stability plus scoreboard pop on every handshake.
   logic       stalled_prev = 1'b0;
   logic [7:0] data_prev = '0;
   logic       last_prev = 1'b0;

   always @(negedge clk) begin
      if (reset_n && pix_valid) begin
         if (stalled_prev) begin
            chk("stall_data", pix_data, data_prev);
            chk("stall_last", pix_last, last_prev);
         end
         if (pix_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
               chk("pix_unexpected", pix_valid, 1'b0);
            end else begin
               pix_t e;
               e = exp_q.pop_front();
               chk("pix_data", pix_data, e.data);
               chk("pix_last", pix_last, e.last);
            end
         end
      end
      stalled_prev = reset_n && pix_valid && !pix_ready;
      data_prev    = pix_data;
      last_prev    = pix_last;
   end

   // Called just after a rising edge; holds req_valid until accepted, returns just after the accept edge.
   task automatic request(input logic [5:0] s, input logic [4:0] r, input logic f,
                          output logic last_seen);
      int n;
      n          = 0;
      req_sprite = s;
      req_row    = r;
      req_flip_x = f;
      req_valid  = 1'b1;
      @(negedge clk);
      while (!req_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("req_accept", req_ready, 1'b1);
      last_seen = pix_last;
      push_line({1'b0, s, r}, f);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic drain(input logic rnd);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 2000) begin
         @(posedge clk);
         #1 pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         n++;
      end
      pix_ready = 1'b1;
      chk("drain_queue", exp_q.size(), 0);
      chk("drain_idle", busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic ls;
      int   hs0;
      int   n;

      // Reset with a request already pending: reset wins.
      req_valid = 1'b1;
      pix_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_pix_valid", pix_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_addr", mem_read_addr, 12'h000);
      chk("rst_pix_data", pix_data, 8'h00);
      chk("rst_pix_last", pix_last, 1'b0);
      req_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rel_req_ready", req_ready, 1'b1);
      chk("rel_busy", busy, 1'b0);
      @(posedge clk);
      #1;

      // Plain line, latency to first pixel.
      request(6'd0, 5'd0, 1'b0, ls);
      @(negedge clk);
      chk("lat_busy", busy, 1'b1);
      chk("lat_addr", mem_read_addr, 12'h000);
      chk("lat_valid_a1", pix_valid, 1'b0);
      @(negedge clk);
      chk("lat_valid_a2", pix_valid, 1'b0);
      chk("lat_req_ready_wait", req_ready, 1'b0);
      @(negedge clk);
      chk("lat_valid_a3", pix_valid, 1'b1);
      @(posedge clk);
      #1;
      drain(1'b0);

      // Mirrored line, then back to IDLE.
      request(6'd0, 5'd0, 1'b1, ls);
      drain(1'b0);
      chk("flip_idle_ready", req_ready, 1'b1);

      // Random back-pressure on a mirrored, non-zero line.
      request(6'd9, 5'd17, 1'b1, ls);
      hs0 = hs_count;
      drain(1'b1);
      chk("rand_hs_count", hs_count - hs0, 32);

      // Back-to-back requests chained on the last-pixel handshake.
      pix_ready = 1'b1;
      request(6'd63, 5'd31, 1'b0, ls);
      @(negedge clk);
      chk("b2b_addr1", mem_read_addr, 12'h7FF);
      @(posedge clk);
      #1;
      request(6'd5, 5'd3, 1'b1, ls);
      chk("b2b_on_last", ls, 1'b1);
      @(negedge clk);
      chk("b2b_busy", busy, 1'b1);
      chk("b2b_no_stream", pix_valid, 1'b0);
      chk("b2b_addr2", mem_read_addr, 12'h0A3);
      @(posedge clk);
      #1;
      drain(1'b0);

      // Reset in the middle of a line.
      request(6'd2, 5'd7, 1'b0, ls);
      hs0 = hs_count;
      n = 0;
      while (hs_count - hs0 < 10 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("mid_pix_valid", pix_valid, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_rst_pix_valid", pix_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_req_ready", req_ready, 1'b0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("mid_rel_req_ready", req_ready, 1'b1);
      @(posedge clk);
      #1;
      request(6'd1, 5'd2, 1'b1, ls);
      drain(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
